// File: rtl/commut_pkg.sv
// Shared definitions for the commutator frame buffer: default geometry,
// idle line level and the drain-side FSM state encoding.
package commut_pkg;

  localparam int   COMMUT_WORDS    = 20;
  localparam int   COMMUT_WIDTH    = 16;
  localparam int   COMMUT_ADR_W    = 5;
  localparam logic COMMUT_IDLE_LVL = 1'b1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    LOAD  = 4'd2,
    START = 4'd3,
    DATA  = 4'd4,
    PAR   = 4'd5,
    STOP  = 4'd6,
    NEXT  = 4'd7,
    DONE  = 4'd8
  } rd_state_t;

endpackage

// File: rtl/commut_bit_tick.sv
// Serial bit-period divider. Counts DIV clk cycles and raises tick on the
// last one; clr restarts the count so each FSM state starts a fresh period.
module commut_bit_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(DIV - 1));
  assign tick   = w_last;

  // Free-running modulo-DIV counter, restarted on every state entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/commut_reader.sv
// Commutator buffer drain: on a rising edge of full, reads words 0..WORDS-1
// and sends each MSB first between a start bit (0) and a stop bit (1).
// Optional build macro COMMUT_RD_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module commut_reader
  import commut_pkg::*;
#(
  parameter int WORDS = COMMUT_WORDS,
  parameter int WIDTH = COMMUT_WIDTH,
  parameter int ADR_W = COMMUT_ADR_W,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             full,
  input  logic [WIDTH-1:0] rdData,
  output logic [ADR_W-1:0] rdAdr,
  output logic             RE,
  output logic             sdo,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int BC_W = $clog2(WIDTH + 1);

  rd_state_t        r_state;
  rd_state_t        w_next;
  logic             r_full_q;
  logic             r_req;
  logic             r_pend;
  logic             r_ovr;
  logic [ADR_W-1:0] r_word_cnt;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
`ifdef COMMUT_RD_PARITY_EN
  logic             r_par;
`endif
  logic             w_tick;
  logic             w_clr;
  logic             w_last_bit;
  logic             w_last_word;

  assign w_clr       = (w_next != r_state);
  assign w_last_bit  = (r_bit_cnt == BC_W'(WIDTH - 1));
  assign w_last_word = (r_word_cnt == ADR_W'(WORDS - 1));
  assign rdAdr       = r_word_cnt;
  assign overrun     = r_ovr;

  commut_bit_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // Registered edge detector on full; a request is one cycle after the rise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full_q <= 1'b0;
      r_req    <= 1'b0;
    end else begin
      r_full_q <= full;
      r_req    <= full & ~r_full_q;
    end
  end

  // One-deep pending request; a further request while pending flags overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (r_state == DONE) begin
      // DONE restarts on either source; one left over stays queued
      r_pend <= r_pend & r_req;
    end else if (r_req && (r_state != IDLE)) begin
      if (r_pend) begin
        r_ovr <= 1'b1;
      end else begin
        r_pend <= 1'b1;
      end
    end
  end

  // Word and bit counters; bit counter restarts with every state entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if ((r_state == IDLE) && r_req) begin
        r_word_cnt <= '0;
      end else if (r_state == NEXT) begin
        r_word_cnt <= w_last_word ? '0 : r_word_cnt + ADR_W'(1);
      end
      if (w_clr) begin
        r_bit_cnt <= '0;
      end else if ((r_state == DATA) && w_tick) begin
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end
    end
  end

  // Word shift register and parity; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (r_state == LOAD) begin
      r_shift <= rdData;
`ifdef COMMUT_RD_PARITY_EN
      r_par   <= ^rdData;
`endif
    end else if ((r_state == DATA) && w_tick) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (r_req) w_next = FETCH;
      FETCH: w_next = LOAD;
      LOAD:  w_next = START;
      START: if (w_tick) w_next = DATA;
      DATA: begin
        if (w_tick && w_last_bit) begin
`ifdef COMMUT_RD_PARITY_EN
          w_next = PAR;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef COMMUT_RD_PARITY_EN
      PAR:   if (w_tick) w_next = STOP;
`endif
      STOP:  if (w_tick) w_next = NEXT;
      NEXT:  w_next = w_last_word ? DONE : FETCH;
      DONE:  w_next = (r_pend || r_req) ? FETCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    RE   = 1'b0;
    sdo  = COMMUT_IDLE_LVL;
    busy = 1'b1;
    done = 1'b0;
    case (r_state)
      IDLE:  busy = 1'b0;
      FETCH: RE   = 1'b1;
      START: sdo  = 1'b0;
      DATA:  sdo  = r_shift[WIDTH-1];
`ifdef COMMUT_RD_PARITY_EN
      PAR:   sdo  = r_par;
`endif
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/commut_reader.md
# commut_reader

Drain side of the commutator frame buffer. When the write-side address generator signals a complete frame on `full`, this block reads the buffer words from address 0 to WORDS-1. It serializes each word onto a single line, MSB first, framed by a start bit and a stop bit, and pulses `done` at frame end. It sits between the commutator buffer RAM read port and the telemetry line driver.

## Interface
Parameters:
- WORDS, 20, words per frame (buffer depth used)
- WIDTH, 16, bits per word
- ADR_W, 5, address width; must satisfy 2^ADR_W ≥ WORDS
- DIV, 4, clk cycles per serial bit; must be ≥ 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- full  in  1  frame-complete flag from the writer; synchronous to clk, level
- rdData  in  WIDTH  buffer read data, valid one cycle after `RE`
- rdAdr  out  ADR_W  buffer read address
- RE  out  1  buffer read enable, one-cycle pulse per word
- sdo  out  1  serial data out; idle level 1
- busy  out  1  high from frame accept to `done`, inclusive
- done  out  1  one-cycle pulse after the last stop bit
- overrun  out  1  sticky; set when a frame request arrives while one is already pending

## Operation
- Frame request = rising edge of `full`. The edge detector is a registered previous value, reset to 0.
- Pending flag, one deep:
  - Set on a request while busy.
  - If already set, `overrun` is set instead.
  - Consumed in DONE: go to FETCH instead of IDLE.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PAR, STOP, NEXT, DONE.
- IDLE: `sdo`=1, `busy`=0. On a request go to FETCH, with word counter = 0 and `busy`=1.
- FETCH: `RE`=1, `rdAdr`=word counter. Go to LOAD.
- LOAD: shift register ← `rdData`; parity ← XOR of `rdData`. Go to START.
- START: `sdo`=0 for DIV cycles.
- DATA: `sdo`=shift[WIDTH-1]. Shift left every DIV cycles; WIDTH bits total.
- PAR: `sdo`=parity for DIV cycles (macro-gated).
- STOP: `sdo`=1 for DIV cycles.
- NEXT, one cycle:
  - If word counter = WORDS-1: counter ← 0, go to DONE.
  - Else: counter +1, go to FETCH.
- DONE: `done`=1 for one cycle. `busy` stays 1 in this cycle. Go to FETCH if pending (clear pending), else IDLE.
- Bit counter is ceil(log2(WIDTH+1)) bits; the DIV tick counter is ceil(log2(DIV)) bits. Both reset to 0 on each state entry.
- Word counter never exceeds WORDS-1; `rdAdr` holds its value outside FETCH.
- `rst` low at any time: all state aborts immediately, and the frame in progress is lost.

## Timing
- Reset values: `rdAdr`=0, `RE`=0, `sdo`=1, `busy`=0, `done`=0, `overrun`=0, pending=0, FSM=IDLE.
- `full` rises at cycle 0 → edge seen at cycle 1 → FETCH (`RE`=1) at cycle 2 → LOAD at cycle 3 → start bit on `sdo` from cycle 4.
- Per word: 2 + (WIDTH+2+P)·DIV + 1 cycles, where P=1 with the macro and 0 without. `sdo`=1 during NEXT/FETCH/LOAD.
- Defaults, P=0: 75 cycles/word; `done` 1500 cycles after the first FETCH.
- `full` falling has no effect. `full` held high does not retrigger.
- A request in the same cycle as DONE is accepted as pending, and is started immediately by that DONE.

## Configuration
- `COMMUT_RD_PARITY_EN` defined: a PAR bit carrying even parity (XOR of the word's data bits) is inserted between DATA and STOP; P=1.
- Undefined: the PAR state is absent and STOP directly follows DATA; P=0.

## Structure
- Shared package `commut_pkg`:
  - FSM state enum `rd_state_t`
  - Constants COMMUT_WORDS=20, COMMUT_WIDTH=16, COMMUT_ADR_W=5, idle line level
- One sub-module, `commut_bit_tick`: the DIV divider. Produces a one-cycle `tick` on its last count; restarts on a `clr` input driven at each state entry.

## Test plan
- Reset mid-frame during DATA of word 7 → `sdo`=1, `busy`=0, `rdAdr`=0 immediately. A new `full` edge restarts from address 0.
- Buffer preloaded with word n = 0xA500+n, then pulse `full` → `RE` pulses at addresses 0..19 in order. Decoded `sdo` is A500..A513, each framed 0…1. `done` fires 1500 cycles after the first `RE` (defaults, no parity).
- Word 0xFFFF and word 0x0001 with the macro defined → parity bits 0 and 1 respectively. Per-word period is 79 cycles.
- Second `full` edge at cycle 300 → `overrun` stays 0. The second frame's FETCH occurs in the cycle after DONE; `busy` never drops between frames.
- Second and third edges both during one frame → `overrun`=1 and sticky. Exactly two frames are transmitted.
- `full` held high for 3000 cycles → exactly one frame; `sdo` idles at 1 after `done`.
